// File: rtl/phase_scheduler_if.sv
// Stage handshake bundle for phase_scheduler: pause/game-over/done requests
// into the scheduler; stage enables, phase code, frame and watchdog status out.
interface phase_scheduler_if #(
  parameter int FRAME_W = 8
);
  logic               pause_i;
  logic               game_over_i;
  logic               d_inp_i;
  logic               d_act_i;
  logic               d_disp_i;
  logic               e_inp_o;
  logic               e_act_o;
  logic               e_disp_o;
  logic [2:0]         phase_o;
  logic [FRAME_W-1:0] frame_o;
  logic               timeout_o;
  logic [3:0]         to_cnt_o;

  modport master (
    input  pause_i, game_over_i,
    input  d_inp_i, d_act_i, d_disp_i,
    output e_inp_o, e_act_o, e_disp_o,
    output phase_o, frame_o,
    output timeout_o, to_cnt_o
  );

  modport slave (
    output pause_i, game_over_i,
    output d_inp_i, d_act_i, d_disp_i,
    input  e_inp_o, e_act_o, e_disp_o,
    input  phase_o, frame_o,
    input  timeout_o, to_cnt_o
  );
endinterface

// File: rtl/phase_scheduler.sv
// Sequences input/action/display stages one at a time with a per-phase watchdog.
// Ports: clk, rst_n (async low), ena (freeze when low), bus (master side).
module phase_scheduler #(
  parameter int TO_CYCLES = 50000,
  parameter int TO_W      = 16,
  parameter int FRAME_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  phase_scheduler_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INPUT   = 3'd1,
    S_ACTION  = 3'd2,
    S_DISPLAY = 3'd3,
    S_PAUSED  = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TO_CYCLES - 1);

  state_t          state;
  state_t          nxt;
  logic [TO_W-1:0] wd;
  logic            active;
  logic            done;
  logic            adv;
  logic            to_evt;

  always_comb begin
    nxt    = state;
    active = 1'b0;
    done   = 1'b0;
    unique case (1'b1)
      state == S_INPUT: begin
        active = 1'b1;
        done   = bus.d_inp_i;
      end
      state == S_ACTION: begin
        active = 1'b1;
        done   = bus.d_act_i;
      end
      state == S_DISPLAY: begin
        active = 1'b1;
        done   = bus.d_disp_i;
      end
      default: ;
    endcase

    // A done on the limit edge wins: it is a normal advance.
    adv    = active && (done || wd == LIMIT);
    to_evt = adv && !done;

    case (state)
      S_IDLE:    nxt = S_INPUT;
      S_INPUT:   if (adv) nxt = S_ACTION;
      S_ACTION:
        if (adv)
          nxt = bus.game_over_i ? S_OVER : S_DISPLAY;
      S_DISPLAY:
        if (adv)
          nxt = bus.pause_i ? S_PAUSED : S_INPUT;
      S_PAUSED:  if (!bus.pause_i) nxt = S_INPUT;
      S_OVER:    nxt = S_OVER;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wd            <= '0;
      bus.e_inp_o   <= 1'b0;
      bus.e_act_o   <= 1'b0;
      bus.e_disp_o  <= 1'b0;
      bus.phase_o   <= 3'd0;
      bus.frame_o   <= '0;
      bus.timeout_o <= 1'b0;
      bus.to_cnt_o  <= 4'd0;
    end else if (ena) begin
      state         <= nxt;
      // Enables decode the next state so they flip on the same edge.
      bus.e_inp_o   <= (nxt == S_INPUT);
      bus.e_act_o   <= (nxt == S_ACTION);
      bus.e_disp_o  <= (nxt == S_DISPLAY) || (nxt == S_OVER);
      bus.phase_o   <= nxt;
      bus.timeout_o <= to_evt;
      if (to_evt && bus.to_cnt_o != 4'd15)
        bus.to_cnt_o <= bus.to_cnt_o + 4'd1;
      if (state == S_DISPLAY && adv)
        bus.frame_o <= bus.frame_o + 1'b1;
      if (!active || nxt != state)
        wd <= '0;
      else
        wd <= wd + 1'b1;
    end
  end

endmodule
